door_controller_pro: RTL

Parametrised next-generation automatic door controller. It tracks door travel position, so a partially closed door reopens only the distance it closed. It extends the hold-open time while motion persists and reverses on obstacles, latching a fault after a configurable number of obstacle retries. Sits between the door sensors (motion, obstacle, lock keyswitch) and the motor driver, replacing the fixed-timing controller in the entrance subsystem.

---
 rtl/door_controller_pro.sv | 127 ++++++++++++
 1 files changed

// File: rtl/door_controller_pro.sv
// Automatic door controller: tracks travel position, extends hold-open on motion,
// reverses on obstacles and latches a fault after too many obstacle retries.
module door_controller_pro #(
    parameter int unsigned TIMER_W      = 8,
    parameter int unsigned TRAVEL_TICKS = 10,
    parameter int unsigned HOLD_TICKS   = 20,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned RETRY_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               motion_sensor,
    input  logic               obstacle_sensor,
    input  logic               lock,
    output logic               door_open,
    output logic               door_close,
    output logic               motor,
    output logic               motor_dir,
    output logic               fault,
    output logic [TIMER_W-1:0] position,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam logic [TIMER_W-1:0] TRAVEL    = TIMER_W'(TRAVEL_TICKS);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_TICKS - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_CLOSED  = 3'd0,
        S_OPENING = 3'd1,
        S_OPEN    = 3'd2,
        S_CLOSING = 3'd3,
        S_STOPPED = 3'd4,
        S_FAULT   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] pos_q, pos_d;
    logic [TIMER_W-1:0] hold_q, hold_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               door_open_q, door_close_q, motor_q, motor_dir_q, fault_q;

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        retry_d = retry_q;
        case (state_q)
            S_CLOSED: begin
                pos_d = '0;
                if (motion_sensor && !lock) state_d = S_OPENING;
            end
            S_OPENING: begin
                // Saturate at full travel so a reopen from the top never overshoots
                if (pos_q >= TRAVEL - TIMER_W'(1)) begin
                    pos_d   = TRAVEL;
                    hold_d  = '0;
                    state_d = S_OPEN;
                end else begin
                    pos_d = pos_q + TIMER_W'(1);
                end
            end
            S_OPEN: begin
                if (motion_sensor)           hold_d  = '0;
                else if (hold_q == HOLD_LAST) state_d = S_CLOSING;
                else                          hold_d  = hold_q + TIMER_W'(1);
            end
            S_CLOSING: begin
                if (obstacle_sensor) begin
                    state_d = S_STOPPED;
                    if (retry_q < RETRY_MAX) retry_d = retry_q + RETRY_W'(1);
                end else if (motion_sensor) begin
                    state_d = S_OPENING;
                end else if (pos_q <= TIMER_W'(1)) begin
                    pos_d   = '0;
                    retry_d = '0;
                    state_d = S_CLOSED;
                end else begin
                    pos_d = pos_q - TIMER_W'(1);
                end
            end
            S_STOPPED: begin
                if (!obstacle_sensor) state_d = (retry_q >= RETRY_MAX) ? S_FAULT : S_OPENING;
            end
            S_FAULT: ;
            default: begin
                state_d = S_CLOSED;
                pos_d   = '0;
            end
        endcase
    end

    // State, counters and Moore outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CLOSED;
            pos_q        <= '0;
            hold_q       <= '0;
            retry_q      <= '0;
            door_open_q  <= 1'b0;
            door_close_q <= 1'b1;
            motor_q      <= 1'b0;
            motor_dir_q  <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            hold_q       <= hold_d;
            retry_q      <= retry_d;
            door_open_q  <= (state_d == S_OPEN);
            door_close_q <= (state_d == S_CLOSED);
            motor_q      <= (state_d == S_OPENING) || (state_d == S_CLOSING);
            motor_dir_q  <= (state_d == S_OPENING);
            fault_q      <= (state_d == S_FAULT);
        end
    end

    assign door_open  = door_open_q;
    assign door_close = door_close_q;
    assign motor      = motor_q;
    assign motor_dir  = motor_dir_q;
    assign fault      = fault_q;
    assign position   = pos_q;
    assign retry_cnt  = retry_q;

endmodule
